// File: rtl/spi_frame_monitor.sv
// Passive SPI frame monitor: header decode, phase tracking, frame/error statistics.
// Define SPI_FRAME_MON_ADDR_LOG_EN to build header address capture for last_addr.
module spi_frame_monitor #(
  parameter int FCNT_W = 16,
  parameter int ECNT_W = 8
) (
  input  logic              SPI_SLAVE_CLK,
  input  logic              HRESETn,
  input  logic              spi_slave_cs,
  input  logic              spi_slave_mosi,
  input  logic              spi_dummy_len,
  input  logic              clr_stat,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [ECNT_W-1:0] err_cnt,
  output logic [3:0]        last_cmd,
  output logic [11:0]       last_addr,
  output logic [7:0]        last_words,
  output logic [3:0]        err_flags
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DUMMY = 3'd2,
    DATA  = 3'd3,
    SKIP  = 3'd4
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [4:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] word_cnt_r;
  logic [3:0] cmd_r;
  logic       clr_meta_r, clr_sync_r;
  logic       close_s;
  logic [3:0] cmd_now_s;
  logic [3:0] err_new_s;

  function automatic logic cmd_valid(input logic [3:0] cmd);
    case (cmd)
      4'h0, 4'h2, 4'h4, 4'h5: cmd_valid = 1'b1;
      default:                cmd_valid = 1'b0;
    endcase
  endfunction

  function automatic logic cmd_is_read(input logic [3:0] cmd);
    cmd_is_read = (cmd == 4'h0) || (cmd == 4'h2);
  endfunction

  assign close_s   = !spi_slave_cs && (state_r != IDLE);
  // Command as it stands once the bit on this edge is included (used at header bit 3)
  assign cmd_now_s = {cmd_r[3:1], spi_slave_mosi};

  // FSM state and shared bit counter registers
  always_ff @(posedge SPI_SLAVE_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r   <= IDLE;
      bit_cnt_r <= 5'd0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
    end
  end

  // Next state and bit counter; any edge with cs low returns to IDLE
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    if (!spi_slave_cs) begin
      state_nxt_s   = IDLE;
      bit_cnt_nxt_s = 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s   = HDR;
          bit_cnt_nxt_s = 5'd1;
        end
        HDR: begin
          bit_cnt_nxt_s = bit_cnt_r + 5'd1;
          if ((bit_cnt_r == 5'd3) && !cmd_valid(cmd_now_s)) begin
            state_nxt_s = SKIP;
          end else if (bit_cnt_r == 5'd15) begin
            state_nxt_s   = cmd_is_read(cmd_r) ? DUMMY : DATA;
            bit_cnt_nxt_s = 5'd0;
          end else begin
            state_nxt_s = HDR;
          end
        end
        DUMMY: begin
          if (bit_cnt_r == (spi_dummy_len ? 5'd31 : 5'd15)) begin
            state_nxt_s   = DATA;
            bit_cnt_nxt_s = 5'd0;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 5'd1;
          end
        end
        DATA:    bit_cnt_nxt_s = bit_cnt_r + 5'd1;
        SKIP:    bit_cnt_nxt_s = bit_cnt_r;
        default: begin
          state_nxt_s   = IDLE;
          bit_cnt_nxt_s = 5'd0;
        end
      endcase
    end
  end

  // Error bits the frame would earn if it closed on this edge
  always_comb begin
    err_new_s = 4'b0000;
    case (state_r)
      HDR:   err_new_s[0] = 1'b1;
      SKIP:  err_new_s[1] = 1'b1;
      DUMMY: err_new_s[3] = 1'b1;
      DATA: begin
        if (cmd_r == 4'h5) begin
          err_new_s[2] = (bit_cnt_r[2:0] != 3'd0);
        end else begin
          err_new_s[2] = (bit_cnt_r != 5'd0);
        end
        err_new_s[3] = (word_cnt_r == 8'd0) && (bit_cnt_r == 5'd0);
      end
      default: err_new_s = 4'b0000;
    endcase
  end

  // Command capture (unreceived bits stay 0) and saturating word count
  always_ff @(posedge SPI_SLAVE_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cmd_r      <= 4'h0;
      word_cnt_r <= 8'd0;
    end else if (spi_slave_cs) begin
      if (state_r == IDLE) begin
        cmd_r      <= {spi_slave_mosi, 3'b000};
        word_cnt_r <= 8'd0;
      end else if ((state_r == HDR) && (bit_cnt_r < 5'd4)) begin
        cmd_r[2'd3 - bit_cnt_r[1:0]] <= spi_slave_mosi;
      end else if ((state_r == DATA) && (bit_cnt_r == 5'd31) && (word_cnt_r != 8'hFF)) begin
        word_cnt_r <= word_cnt_r + 8'd1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous clear request
  always_ff @(posedge SPI_SLAVE_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      clr_meta_r <= 1'b0;
      clr_sync_r <= 1'b0;
    end else begin
      clr_meta_r <= clr_stat;
      clr_sync_r <= clr_meta_r;
    end
  end

  // Close bookkeeping; clear dominates the counters but not the last-frame info
  always_ff @(posedge SPI_SLAVE_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      frame_done <= 1'b0;
      frame_cnt  <= {FCNT_W{1'b0}};
      err_cnt    <= {ECNT_W{1'b0}};
      err_flags  <= 4'b0000;
      last_cmd   <= 4'h0;
      last_words <= 8'd0;
    end else begin
      frame_done <= close_s;
      if (close_s) begin
        last_cmd   <= cmd_r;
        last_words <= word_cnt_r;
      end
      if (clr_sync_r) begin
        frame_cnt <= {FCNT_W{1'b0}};
        err_cnt   <= {ECNT_W{1'b0}};
        err_flags <= 4'b0000;
      end else if (close_s) begin
        frame_cnt <= frame_cnt + {{(FCNT_W-1){1'b0}}, 1'b1};
        if (err_new_s != 4'b0000) begin
          if (err_cnt != {ECNT_W{1'b1}}) begin
            err_cnt <= err_cnt + {{(ECNT_W-1){1'b0}}, 1'b1};
          end
          err_flags <= err_flags | err_new_s;
        end
      end
    end
  end

`ifdef SPI_FRAME_MON_ADDR_LOG_EN
  logic [11:0] addr_r;

  // Header address capture; bits ignored in SKIP leave the address at 0
  always_ff @(posedge SPI_SLAVE_CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r    <= 12'h000;
      last_addr <= 12'h000;
    end else begin
      if (spi_slave_cs && (state_r == IDLE)) begin
        addr_r <= 12'h000;
      end else if (spi_slave_cs && (state_r == HDR) && (bit_cnt_r >= 5'd4)) begin
        addr_r[4'd15 - bit_cnt_r[3:0]] <= spi_slave_mosi;
      end
      if (close_s) begin
        last_addr <= addr_r;
      end
    end
  end
`else
  assign last_addr = 12'h000;
`endif

endmodule
